// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline has absolute priority, and
// multi-cycle unit results wait in a small FIFO that decode can bypass from.
module wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        div_valid,
  input  logic [4:0]  div_waddr,
  input  logic [31:0] div_wdata,
  output logic        div_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_hit1,
  output logic        q_hit2,
  output logic [31:0] q_data1,
  output logic [31:0] q_data2,
  output logic        stall_req
);

  // Storage is sized for the largest legal DEPTH; only DEPTH slots are used.
  localparam int unsigned MAXD = 4;
  localparam int unsigned PW   = 2;
  localparam int unsigned CW   = 3;

  logic [MAXD-1:0] valid_q, valid_d;
  logic [4:0]      waddr_q [MAXD];
  logic [4:0]      waddr_d [MAXD];
  logic [31:0]     wdata_q [MAXD];
  logic [31:0]     wdata_d [MAXD];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic          push, pop, squash, push_valid;
  logic [PW-1:0] idx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? PW'(0) : p + PW'(1);
  endfunction

  // Write-port arbitration, handshake and FIFO next state.
  always_comb begin
    div_ready  = !rst && (count_q < CW'(DEPTH));
    stall_req  = !rst && (count_q == CW'(DEPTH));
    push       = div_valid && div_ready;
    pop        = !rst && !pipe_we && (count_q != '0);
    squash     = !rst && pipe_we && (pipe_waddr != '0);
    push_valid = (div_waddr != '0) && !(squash && (pipe_waddr == div_waddr));

    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (pipe_we) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
      end else if (pop && valid_q[head_q]) begin
        rf_we    = 1'b1;
        rf_waddr = waddr_q[head_q];
        rf_wdata = wdata_q[head_q];
      end
    end

    valid_d = valid_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // A younger pipeline write makes any pending result to that register stale.
    if (squash) begin
      for (int i = 0; i < int'(MAXD); i++) begin
        if (waddr_q[i] == pipe_waddr) valid_d[i] = 1'b0;
      end
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = nxt(head_q);
    end
    if (push) begin
      valid_d[tail_q] = push_valid;
      waddr_d[tail_q] = div_waddr;
      wdata_d[tail_q] = div_wdata;
      tail_d          = nxt(tail_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Bypass lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = '0;
    q_data2 = '0;
    idx     = '0;
    if (!rst) begin
      for (int i = 0; i < int'(MAXD); i++) begin
        if (i < int'(DEPTH) && i < int'(count_q)) begin
          idx = PW'((int'(head_q) + i) % int'(DEPTH));
          if (valid_q[idx] && q_addr1 != '0 && waddr_q[idx] == q_addr1) begin
            q_hit1  = 1'b1;
            q_data1 = wdata_q[idx];
          end
          if (valid_q[idx] && q_addr2 != '0 && waddr_q[idx] == q_addr2) begin
            q_hit2  = 1'b1;
            q_data2 = wdata_q[idx];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(MAXD); i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < int'(MAXD); i++) begin
        waddr_q[i] <= waddr_d[i];
        wdata_q[i] <= wdata_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=2): priority, buffering, squash,
// bypass lookup, reset discard and pointer wrap.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        div_valid;
  logic [4:0]  div_waddr;
  logic [31:0] div_wdata;
  logic        div_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_hit1, q_hit2;
  logic [31:0] q_data1, q_data2;
  logic        stall_req;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .div_valid(div_valid), .div_waddr(div_waddr), .div_wdata(div_wdata),
    .div_ready(div_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_we = we; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic div(input logic v, input logic [4:0] a, input logic [31:0] d);
    div_valid = v; div_waddr = a; div_wdata = d;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_data"}, rf_wdata, d);
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    div(1'b0, 5'd0, 32'h0);
    q_addr1 = 5'd0;
    q_addr2 = 5'd0;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    chk_rf("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_ready", 32'(div_ready), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(div_ready), 32'd1);
    chk("post_rst_stall", 32'(stall_req), 32'd0);
    chk_rf("idle", 1'b0, 5'd0, 32'h0);
    tick();

    // Single push, one-cycle minimum latency
    div(1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    chk("no_passthru_we", 32'(rf_we), 32'd0);
    chk("push_ready", 32'(div_ready), 32'd1);
    tick();
    div(1'b0, 5'd0, 32'h0);
    q_addr1 = 5'd5;
    @(negedge clk);
    chk_rf("pop5", 1'b1, 5'd5, 32'h1234);
    chk("pop5_hit", 32'(q_hit1), 32'd1);
    chk("pop5_qdata", q_data1, 32'h1234);
    tick();
    @(negedge clk);
    chk_rf("empty_again", 1'b0, 5'd0, 32'h0);
    chk("empty_hit", 32'(q_hit1), 32'd0);
    q_addr1 = 5'd0;
    tick();

    // Pipeline priority, fill to full, then in-order drain
    pipe(1'b1, 5'd10, 32'hA0);
    div(1'b1, 5'd1, 32'h11);
    @(negedge clk);
    chk_rf("prio0", 1'b1, 5'd10, 32'hA0);
    tick();
    pipe(1'b1, 5'd11, 32'hA1);
    div(1'b1, 5'd2, 32'h22);
    @(negedge clk);
    chk_rf("prio1", 1'b1, 5'd11, 32'hA1);
    chk("prio1_ready", 32'(div_ready), 32'd1);
    tick();
    pipe(1'b1, 5'd12, 32'hA2);
    div(1'b1, 5'd3, 32'h33);
    @(negedge clk);
    chk_rf("prio2", 1'b1, 5'd12, 32'hA2);
    chk("full_ready", 32'(div_ready), 32'd0);
    chk("full_stall", 32'(stall_req), 32'd1);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    div(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_rf("drain1", 1'b1, 5'd1, 32'h11);
    chk("drain1_stall", 32'(stall_req), 32'd1);
    tick();
    @(negedge clk);
    chk_rf("drain2", 1'b1, 5'd2, 32'h22);
    chk("drain2_stall", 32'(stall_req), 32'd0);
    chk("drain2_ready", 32'(div_ready), 32'd1);
    tick();
    @(negedge clk);
    chk_rf("drain_done", 1'b0, 5'd0, 32'h0);
    tick();

    // Younger pipeline write squashes a buffered result
    div(1'b1, 5'd7, 32'hAAAA);
    tick();
    div(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd7, 32'hBBBB);
    q_addr1 = 5'd7;
    @(negedge clk);
    chk_rf("squash_pipe", 1'b1, 5'd7, 32'hBBBB);
    chk("squash_pending_hit", 32'(q_hit1), 32'd1);
    chk("squash_pending_data", q_data1, 32'hAAAA);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_rf("squash_pop", 1'b0, 5'd0, 32'h0);
    chk("squash_hit", 32'(q_hit1), 32'd0);
    tick();
    @(negedge clk);
    chk_rf("squash_empty", 1'b0, 5'd0, 32'h0);
    q_addr1 = 5'd0;

    // Squash of the entry being pushed in the same cycle
    pipe(1'b1, 5'd8, 32'h8888);
    div(1'b1, 5'd8, 32'h9999);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    div(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_rf("same_cycle_squash", 1'b0, 5'd0, 32'h0);
    chk("same_cycle_stall", 32'(stall_req), 32'd0);
    tick();

    // Result to r0 is accepted but never written
    div(1'b1, 5'd0, 32'h55);
    @(negedge clk);
    chk("r0_ready", 32'(div_ready), 32'd1);
    tick();
    div(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_rf("r0_pop", 1'b0, 5'd0, 32'h0);
    tick();

    // Youngest match wins on bypass lookup
    pipe(1'b1, 5'd20, 32'h20);
    div(1'b1, 5'd3, 32'h1);
    tick();
    div(1'b1, 5'd3, 32'h2);
    tick();
    div(1'b0, 5'd0, 32'h0);
    q_addr1 = 5'd3;
    q_addr2 = 5'd0;
    @(negedge clk);
    chk("young_hit1", 32'(q_hit1), 32'd1);
    chk("young_data1", q_data1, 32'h2);
    chk("zero_hit2", 32'(q_hit2), 32'd0);
    chk("zero_data2", q_data2, 32'h0);
    chk("young_stall", 32'(stall_req), 32'd1);

    // Reset with a full buffer and a result on offer
    pipe(1'b0, 5'd0, 32'h0);
    div(1'b1, 5'd9, 32'h99);
    rst = 1'b1;
    @(negedge clk);
    chk_rf("mid_rst", 1'b0, 5'd0, 32'h0);
    chk("mid_rst_ready", 32'(div_ready), 32'd0);
    chk("mid_rst_stall", 32'(stall_req), 32'd0);
    chk("mid_rst_hit", 32'(q_hit1), 32'd0);
    tick();
    rst = 1'b0;
    div(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("after_rst_ready", 32'(div_ready), 32'd1);
    chk("after_rst_stall", 32'(stall_req), 32'd0);
    chk_rf("after_rst", 1'b0, 5'd0, 32'h0);
    chk("after_rst_hit", 32'(q_hit1), 32'd0);
    tick();
    @(negedge clk);
    chk_rf("after_rst2", 1'b0, 5'd0, 32'h0);
    q_addr1 = 5'd0;
    tick();

    // Wrap: push every cycle, each pops the previous result the next cycle
    for (int k = 1; k <= 6; k++) begin
      div(1'b1, 5'(k + 12), 32'h100 + 32'(k));
      @(negedge clk);
      chk("wrap_ready", 32'(div_ready), 32'd1);
      if (k == 1) chk_rf("wrap_first", 1'b0, 5'd0, 32'h0);
      else        chk_rf("wrap", 1'b1, 5'(k + 11), 32'h100 + 32'(k - 1));
      tick();
    end
    div(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_rf("wrap_last", 1'b1, 5'd18, 32'h106);
    tick();
    @(negedge clk);
    chk_rf("wrap_empty", 1'b0, 5'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of pending-result buffer entries (legal 1..4).
REQ-002 SHALL have clk input 1: clock; all state updates on rising edge.
REQ-003 SHALL have rst input 1: reset, synchronous, active-high.
REQ-004 SHALL have pipe_we input 1: pipeline (MEM/WB) write-back request.
REQ-005 SHALL have pipe_waddr input 5: pipeline destination register.
REQ-006 SHALL have pipe_wdata input 32: pipeline write data.
REQ-007 SHALL have div_valid input 1: multi-cycle unit result valid.
REQ-008 SHALL have div_waddr input 5: multi-cycle result destination register.
REQ-009 SHALL have div_wdata input 32: multi-cycle result data.
REQ-010 SHALL have div_ready output 1: buffer can accept a multi-cycle result this cycle.
REQ-011 SHALL have rf_we output 1: register-file write enable.
REQ-012 SHALL have rf_waddr output 5: register-file write address.
REQ-013 SHALL have rf_wdata output 32: register-file write data.
REQ-014 SHALL have q_addr1 and q_addr2, inputs, 5 bits each: decode-stage bypass lookup addresses.
REQ-015 SHALL have q_hit1 and q_hit2, outputs, 1 bit each: lookup matched a pending buffered result.
REQ-016 SHALL have q_data1 and q_data2, outputs, 32 bits each: matched pending data, else 0.
REQ-017 SHALL have stall_req output 1: buffer full, request pipeline hold.

Function
REQ-018 SHALL own the single register-file write port; all outputs SHALL be combinational from inputs and buffer state.
REQ-019 SHALL hold a FIFO of DEPTH entries {valid, waddr, wdata} with head/tail pointers and occupancy count 0..DEPTH; pointers SHALL wrap modulo DEPTH.
REQ-020 SHALL give the pipeline absolute priority: pipe_we=1 -> rf_we=1, rf_waddr=pipe_waddr, rf_wdata=pipe_wdata, no pop.
REQ-021 SHALL, when pipe_we=0 and count>0, pop the head; if head valid=1, drive rf_we=1 with head waddr/wdata; if valid=0 (squashed), drive rf_we=0 and still pop.
REQ-022 SHALL drive rf_we=0, rf_waddr=0 and rf_wdata=0 when neither source writes.
REQ-023 SHALL assert div_ready = (count < DEPTH); no pass-through: push only when div_valid and div_ready; an accepted result reaches rf no earlier than the next cycle (minimum latency 1).
REQ-024 SHALL accept but store as valid=0 a result with div_waddr=0.
REQ-025 SHALL support simultaneous push and pop in one cycle; count unchanged.
REQ-026 SHALL, on pipe_we=1 with pipe_waddr!=0, clear valid of every buffered entry whose waddr equals pipe_waddr (younger pipeline write supersedes older pending result), including an entry being pushed that cycle.
REQ-027 SHALL assert stall_req = (count == DEPTH).
REQ-028 SHALL compute q_hitN=1 when qaddrN!=0 and some valid entry has waddr=qaddrN; q_dataN SHALL be the youngest matching entry's wdata; else q_hitN=0, q_dataN=0.
REQ-029 SHALL exclude an entry popped this cycle from no lookup (it is still pending until the edge).

Reset
REQ-030 SHALL, while rst=1, force rf_we=0, div_ready=0, stall_req=0, q_hit1/2=0 and all data/address outputs 0.
REQ-031 SHALL, at a clock edge with rst=1, clear all valid bits, head, tail and count to 0; a result offered mid-reset SHALL be discarded.
REQ-032 SHALL resume accepting results in the first cycle after rst deasserts (div_ready=1).

Verification
REQ-033 Idle, div push {r5, 0x1234} with pipe_we=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, count returns 0.
REQ-034 Pipeline writes every cycle while 2 div results pushed -> div_ready=0 and stall_req=1 after 2nd push; buffered writes drain in order once pipe_we drops.
REQ-035 Buffered {r7, 0xAAAA}, then pipe_we r7 0xBBBB -> rf gets 0xBBBB only; later pop of r7 entry has rf_we=0.
REQ-036 Two buffered entries r3 (0x1, older) and r3 (0x2), q_addr1=3 -> q_hit1=1, q_data1=0x2; q_addr2=0 -> q_hit2=0.
REQ-037 Full buffer, rst=1 for one cycle with div_valid=1 -> after reset count=0, no rf write of old or offered data, div_ready=1.
REQ-038 DEPTH=2 wrap test: 6 alternating push/pop cycles with pipe_we=0 -> rf writes appear in push order, no loss or duplication.
